// File: rtl/vertex_transform_seq.sv
// vertex_transform_seq: walks a vertex list, applies v = u*A + t to each vertex
// through one shared 2x2 row-vector x matrix multiplier, and streams the results
// out on a valid/ready port.
//
// Output handshake: out_valid rises with a result and then stays high, with
// out_x/out_y/out_idx/out_last frozen, until the cycle where out_ready is also
// high. A transfer happens on any rising edge where out_valid & out_ready.

`ifndef FLOAT_BITS
`define FLOAT_BITS 16
`endif
`ifndef FLOAT_DCM_BITS
`define FLOAT_DCM_BITS 8
`endif

// Row vector (u1,u2) times a 2x2 matrix plus translation, wrapped to W bits.
module vt_vecmat2 #(
  parameter int W = 16,
  parameter int D = 8
) (
  input  logic signed [W-1:0] u1_i,
  input  logic signed [W-1:0] u2_i,
  input  logic signed [W-1:0] a11_i,
  input  logic signed [W-1:0] a12_i,
  input  logic signed [W-1:0] a21_i,
  input  logic signed [W-1:0] a22_i,
  input  logic signed [W-1:0] tx_i,
  input  logic signed [W-1:0] ty_i,
  output logic signed [W-1:0] v1_o,
  output logic signed [W-1:0] v2_o
);
  localparam int PW = 2 * W;

  logic signed [PW-1:0] u1_x, u2_x;
  logic signed [PW-1:0] p11, p12, p21, p22;

  assign u1_x = PW'(u1_i);
  assign u2_x = PW'(u2_i);
  assign p11  = u1_x * PW'(a11_i);
  assign p12  = u1_x * PW'(a12_i);
  assign p21  = u2_x * PW'(a21_i);
  assign p22  = u2_x * PW'(a22_i);

  // Each product is rescaled on its own before summing; the sum simply wraps.
  assign v1_o = W'((p11 >>> D) + (p21 >>> D) + PW'(tx_i));
  assign v2_o = W'((p12 >>> D) + (p22 >>> D) + PW'(ty_i));
endmodule

module vertex_transform_seq #(
  parameter int MAX_VERTS = 8,
  parameter int ADDR_BITS = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_BITS:0]             vert_count,
  input  logic signed [`FLOAT_BITS-1:0]  a11,
  input  logic signed [`FLOAT_BITS-1:0]  a12,
  input  logic signed [`FLOAT_BITS-1:0]  a21,
  input  logic signed [`FLOAT_BITS-1:0]  a22,
  input  logic signed [`FLOAT_BITS-1:0]  tx,
  input  logic signed [`FLOAT_BITS-1:0]  ty,
  output logic                           busy,
  output logic                           done,
  output logic                           rd_en,
  output logic [ADDR_BITS-1:0]           rd_addr,
  input  logic signed [`FLOAT_BITS-1:0]  rd_x,
  input  logic signed [`FLOAT_BITS-1:0]  rd_y,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [`FLOAT_BITS-1:0]  out_x,
  output logic signed [`FLOAT_BITS-1:0]  out_y,
  output logic [ADDR_BITS-1:0]           out_idx,
  output logic                           out_last,
  output logic [2:0]                     dbg_state_o
);
  localparam int W  = `FLOAT_BITS;
  localparam int D  = `FLOAT_DCM_BITS;
  localparam int CW = ADDR_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_CALC  = 3'd3,
    S_EMIT  = 3'd4
  } state_t;

  state_t               state_q;
  logic signed [W-1:0]  a11_q, a12_q, a21_q, a22_q, tx_q, ty_q;
  logic signed [W-1:0]  u1_q, u2_q;
  logic signed [W-1:0]  out_x_q, out_y_q;
  logic [CW-1:0]        n_q;
  logic [CW-1:0]        n_d;
  logic [ADDR_BITS-1:0] idx_q, out_idx_q;
  logic                 out_last_q, out_valid_q;
  logic                 busy_q, done_q, rd_en_q;
  logic                 is_last;
  logic signed [W-1:0]  mul_x, mul_y;

  // Requested count clamped to the job capacity.
  assign n_d = (vert_count > CW'(MAX_VERTS)) ? CW'(MAX_VERTS) : vert_count;

  // idx is the final vertex when idx + 1 reaches n (never wraps: idx < MAX_VERTS).
  assign is_last = (({1'b0, idx_q} + CW'(1)) == n_q);

  vt_vecmat2 #(.W(W), .D(D)) u_vecmat (
    .u1_i  (u1_q),
    .u2_i  (u2_q),
    .a11_i (a11_q),
    .a12_i (a12_q),
    .a21_i (a21_q),
    .a22_i (a22_q),
    .tx_i  (tx_q),
    .ty_i  (ty_q),
    .v1_o  (mul_x),
    .v2_o  (mul_y)
  );

  // Sequencer FSM: all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a11_q       <= '0;
      a12_q       <= '0;
      a21_q       <= '0;
      a22_q       <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      u1_q        <= '0;
      u2_q        <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a11_q <= a11;
            a12_q <= a12;
            a21_q <= a21;
            a22_q <= a22;
            tx_q  <= tx;
            ty_q  <= ty;
            n_q   <= n_d;
            idx_q <= '0;
            if (n_d == '0) begin
              // Empty job completes immediately without leaving IDLE.
              done_q <= 1'b1;
            end else begin
              state_q <= S_READ;
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          rd_en_q <= 1'b0;
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          u1_q    <= rd_x;
          u2_q    <= rd_y;
          state_q <= S_CALC;
        end
        S_CALC: begin
          out_x_q     <= mul_x;
          out_y_q     <= mul_y;
          out_idx_q   <= idx_q;
          out_last_q  <= is_last;
          out_valid_q <= 1'b1;
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (is_last) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_q + ADDR_BITS'(1);
              state_q <= S_READ;
              rd_en_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          rd_en_q     <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = idx_q;
  assign out_valid   = out_valid_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_idx     = out_idx_q;
  assign out_last    = out_last_q;
  assign dbg_state_o = state_q;
endmodule
